// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped GPIO bank.
// Holds the per-channel register offsets, the channel window stride and
// the address decoder used by mmio_gpio_bank.
package mmio_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CH_STRIDE = 16;
    localparam int unsigned CH_SHIFT  = 4;   // log2(CH_STRIDE)
    localparam int unsigned CH_IDX_W  = 3;   // up to 8 channels

    localparam logic [3:0] OFS_OUT   = 4'h0;
    localparam logic [3:0] OFS_IN    = 4'h4;
    localparam logic [3:0] OFS_IRQEN = 4'h8;
    localparam logic [3:0] OFS_EDGE  = 4'hC;

    typedef enum logic [1:0] {
        REG_OUT   = 2'd0,
        REG_IN    = 2'd1,
        REG_IRQEN = 2'd2,
        REG_EDGE  = 2'd3
    } reg_sel_e;

    typedef struct packed {
        logic                valid;
        logic [CH_IDX_W-1:0] ch;
        reg_sel_e            sel;
    } decode_t;

    // Split a byte address into channel index and register select.
    // valid only for word-aligned addresses inside the bank's window.
    function automatic decode_t decode_addr(input logic [ADDR_W-1:0] addr,
                                            input logic [ADDR_W-1:0] base,
                                            input int unsigned       nch);
        decode_t           d;
        logic [ADDR_W-1:0] ofs;
        ofs     = addr - base;
        d.valid = (addr >= base) &&
                  (ofs < ADDR_W'(CH_STRIDE * nch)) &&
                  (addr[1:0] == 2'b00);
        d.ch    = ofs[CH_SHIFT +: CH_IDX_W];
        case (ofs[3:0])
            OFS_OUT:   d.sel = REG_OUT;
            OFS_IN:    d.sel = REG_IN;
            OFS_IRQEN: d.sel = REG_IRQEN;
            OFS_EDGE:  d.sel = REG_EDGE;
            default:   d.sel = REG_OUT;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser and rising-edge detector for one GPIO channel.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   async_in    - external pins, asynchronous to clk
//   sync_out    - pins after SYNC_STAGES flops
//   rise_c      - combinational rising-edge vector (sync_out & ~previous)
// Build option GPIO_IRQ_EN: when undefined the edge detector is not
// built and rise_c is tied to 0.
module gpio_sync_edge #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise_c
);

    localparam int unsigned CHAIN_W = SYNC_STAGES * WIDTH;

    logic [CHAIN_W-1:0] chain_q;

    // Synchroniser chain; newest sample enters at the low end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[CHAIN_W-WIDTH-1:0], async_in};
        end
    end

    assign sync_out = chain_q[CHAIN_W-1 -: WIDTH];

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] prev_q;

    // prev resets to 0, so a pin held high through reset reports a rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync_out;
        end
    end

    assign rise_c = sync_out & ~prev_q;
`else
    assign rise_c = '0;
`endif

endmodule

// File: rtl/mmio_gpio_bank.sv
// Memory-mapped GPIO bank: NCH channels of WIDTH-bit output/input ports.
// Per-channel window at BASE_ADDR + 16*c:
//   +0 OUT (rw), +4 IN (ro), +8 IRQEN (rw), +C EDGE (w1c sticky rises)
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   addr, wdata   - data bus address and store data
//   we            - store strobe from the core
//   hit           - combinational: addr selects a register of this bank
//   rdata         - combinational read data, zero-extended
//   port_in       - external inputs, channel c at [c*WIDTH +: WIDTH]
//   port_out      - registered outputs, same packing
//   irq           - registered interrupt request
// Build option GPIO_IRQ_EN: when undefined IRQEN/EDGE/irq are not built,
// their reads return 0, writes are ignored and irq is tied to 0.
module mmio_gpio_bank
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h800,
    parameter int unsigned NCH         = 2,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    input  logic                   we,
    output logic                   hit,
    output logic [31:0]            rdata,
    input  logic [NCH*WIDTH-1:0]   port_in,
    output logic [NCH*WIDTH-1:0]   port_out,
    output logic                   irq
);

    decode_t          dec;
    logic             wr_en;
    logic [WIDTH-1:0] out_q   [NCH];
    logic [WIDTH-1:0] in_sync [NCH];
    logic [WIDTH-1:0] rise_c  [NCH];
    logic [WIDTH-1:0] rd_sel;
    logic             unused_wdata;

    assign dec          = decode_addr(addr, BASE_ADDR, NCH);
    assign hit          = dec.valid;
    assign wr_en        = we & dec.valid;
    assign unused_wdata = ^wdata;

    // Per-channel synchroniser and pin packing.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        gpio_sync_edge #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .clk      (clk),
            .reset    (reset),
            .async_in (port_in[c*WIDTH +: WIDTH]),
            .sync_out (in_sync[c]),
            .rise_c   (rise_c[c])
        );
        assign port_out[c*WIDTH +: WIDTH] = out_q[c];
    end

    // OUT registers drive the pins directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < NCH; c++) out_q[c] <= '0;
        end else if (wr_en && dec.sel == REG_OUT) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (dec.ch == CH_IDX_W'(c)) out_q[c] <= wdata[WIDTH-1:0];
            end
        end
    end

`ifdef GPIO_IRQ_EN
    logic [WIDTH-1:0] irqen_q [NCH];
    logic [WIDTH-1:0] edge_q  [NCH];
    logic [WIDTH-1:0] clr_c   [NCH];
    logic             irq_q;
    logic             irq_next_c;

    // Write-1-to-clear masks and the interrupt reduction of current state.
    always_comb begin
        irq_next_c = 1'b0;
        for (int unsigned c = 0; c < NCH; c++) begin
            clr_c[c] = '0;
            if (wr_en && dec.sel == REG_EDGE && dec.ch == CH_IDX_W'(c)) begin
                clr_c[c] = wdata[WIDTH-1:0];
            end
            irq_next_c = irq_next_c | (|(edge_q[c] & irqen_q[c]));
        end
    end

    // IRQEN, sticky EDGE (a same-cycle rise beats the clear) and irq.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                irqen_q[c] <= '0;
                edge_q[c]  <= '0;
            end
            irq_q <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                edge_q[c] <= (edge_q[c] & ~clr_c[c]) | rise_c[c];
                if (wr_en && dec.sel == REG_IRQEN && dec.ch == CH_IDX_W'(c)) begin
                    irqen_q[c] <= wdata[WIDTH-1:0];
                end
            end
            irq_q <= irq_next_c;
        end
    end

    assign irq = irq_q;
`else
    logic unused_rise;

    always_comb begin
        unused_rise = 1'b0;
        for (int unsigned c = 0; c < NCH; c++) begin
            unused_rise = unused_rise | (|rise_c[c]);
        end
    end

    assign irq = 1'b0;
`endif

    // Combinational read mux for the single-cycle core.
    always_comb begin
        rd_sel = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (dec.ch == CH_IDX_W'(c)) begin
                case (dec.sel)
                    REG_OUT:   rd_sel = out_q[c];
                    REG_IN:    rd_sel = in_sync[c];
`ifdef GPIO_IRQ_EN
                    REG_IRQEN: rd_sel = irqen_q[c];
                    REG_EDGE:  rd_sel = edge_q[c];
`endif
                    default:   rd_sel = '0;
                endcase
            end
        end
        rdata = dec.valid ? DATA_W'(rd_sel) : '0;
    end

endmodule

// File: doc/mmio_gpio_bank.md
Name: mmio_gpio_bank

Overview:
Parametrised memory-mapped I/O bank for the single-cycle ARM core. It is the successor to the fixed single 8-bit in/out port pair at 0x800.
- Provides NCH channels of WIDTH-bit output and input ports.
- Inputs pass through synchronisers, with rising-edge capture and a maskable interrupt.
- Sits beside dmem on the data bus. It supplies the hit signal that steers the read-data mux.

Parameters:
BASE_ADDR  32'h800  byte address of channel 0, register 0; must be 16-byte aligned
NCH  2  number of channels (1..8)
WIDTH  8  bits per channel (1..32)
SYNC_STAGES  2  input synchroniser depth (>=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
addr  input  32  data address (ALUResult)
wdata  input  32  store data
we  input  1  MemWrite from core
hit  output  1  addr decodes to a valid register of this block
rdata  output  32  read data, zero-extended from WIDTH
port_in  input  NCH*WIDTH  external inputs, asynchronous to clk; channel c at [c*WIDTH +: WIDTH]
port_out  output  NCH*WIDTH  registered outputs; same packing as port_in
irq  output  1  registered interrupt request, active-high

Behaviour:
- Register map: channel c window at BASE_ADDR + 16*c.
  - +0 OUT: read/write.
  - +4 IN: read-only, synchronised value.
  - +8 IRQEN: read/write.
  - +C EDGE: sticky rising-edge flags, write-1-to-clear.
- Address decode:
  - hit = 1 when addr is in [BASE_ADDR, BASE_ADDR + 16*NCH) and addr[1:0] == 0.
  - Misaligned or out-of-window addresses give hit = 0 and rdata = 0.
- Reads are combinational, as required by the single-cycle core.
  - rdata = {(32-WIDTH)'0, selected register} when hit, else 0.
- Writes take effect on the posedge when we & hit.
  - Only wdata[WIDTH-1:0] is used.
  - A write to IN is ignored.
  - A write to EDGE clears the bits where wdata is 1 and leaves the rest unchanged.
- port_out[c] = OUT[c], driven directly from the register. A write is visible on the pin on the cycle after the write edge.
- Synchroniser:
  - Each bit passes through SYNC_STAGES flops.
  - A pin change is visible in IN after SYNC_STAGES rising edges.
- Edge detect:
  - prev[c] holds IN from the previous cycle.
  - rise = IN & ~prev.
  - EDGE <= (EDGE & ~clr) | rise, where clr is the write-1-to-clear mask from the current write.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- irq is registered one cycle behind the state: irq <= |(EDGE[c] & IRQEN[c]) over all c.
  - Clearing the last enabled flag drops irq one cycle after the write edge.
- Reset:
  - All OUT, IRQEN, EDGE, synchroniser and prev flops are cleared to 0, so port_out = 0 and irq = 0.
  - hit and rdata stay combinational and decode normally during reset.
  - Asserting reset mid-operation clears everything immediately. Writes during reset are dropped.
- Power-up edge: an input held high through reset sets its EDGE bit SYNC_STAGES+1 cycles after reset release, because prev resets to 0. This is documented behaviour; firmware clears EDGE at init.
- Top-level integration: the ReadData mux select is hit. Dmem is not inhibited on a hit; its data is simply not selected.

Optional Feature:
GPIO_IRQ_EN
- Defined: IRQEN and EDGE registers, edge-detect logic and irq are implemented as above.
- Undefined: those flops and the edge logic are not built.
  - Reads of +8 and +C return 0; writes to them are ignored.
  - hit still covers them.
  - irq is tied to 0.

Decomposition:
- Package mmio_pkg holds:
  - offset constants OFS_OUT = 4'h0, OFS_IN = 4'h4, OFS_IRQEN = 4'h8, OFS_EDGE = 4'hC;
  - CH_STRIDE = 16;
  - a function that decodes addr into channel index and register select.
- One sub-module, gpio_sync_edge, is instantiated NCH times:
  - parameters WIDTH and SYNC_STAGES;
  - inputs clk, reset and the async input;
  - outputs the synchronised value and a one-cycle rise vector.
- The top handles decode, the register array and irq.

Test Plan:
1. Reset with NCH=2, WIDTH=8 -> port_out = 0, irq = 0; read 0x800..0x81C returns 0.
2. Write 0xA5 to 0x800 and 0x3C to 0x810 -> next cycle port_out = 16'h3CA5; readback returns 0x000000A5 and 0x0000003C.
3. port_in channel 0 set to 0x81 -> read 0x804 returns 0 for the first SYNC_STAGES-1 cycles and 0x81 from cycle SYNC_STAGES; EDGE at 0x80C reads 0x81 one cycle later.
4. IRQEN0 = 0x01, then bit 0 rises -> irq rises one cycle after EDGE sets. Write 0x01 to 0x80C -> irq falls one cycle after the write edge. A new rise in the same cycle as the clear keeps the flag set.
5. Accesses to 0x820, 0x801 and 0x7FC -> hit = 0 and rdata = 0; a write with we = 1 leaves all registers unchanged.
6. Reset asserted mid-cycle with OUT = 0xFF and irq = 1 -> port_out and irq go to 0 immediately, without waiting for a clock edge. Build without GPIO_IRQ_EN -> reads of 0x808 and 0x80C return 0, and irq stays 0 under input toggling.
